uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: accepts bytes through a single-cycle write strobe into an internal FIFO and serialises them on txOutput as 8N1 frames (start bit, 8 data bits LSB first, stop bit) at a fixed baud divisor.
- Sits on the transmit side of the UART top alongside the existing receiver.
- Lets upstream logic (e.g. an echo path or a message generator) push bursts of bytes without waiting for the completion of each frame.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
- AW, 4, FIFO address width, log2(DEPTH).

Ports:
- clkInput  input  1  system clock; rising edge active.
- rstnInput  input  1  reset, asynchronous, active-low.
- sendData  input  8  byte to enqueue; sampled when sendStart=1.
- sendStart  input  1  write strobe; one byte enqueued per high cycle when not full.
- txOutput  output  1  serial line; idle high.
- sendCompFlag  output  1  one-cycle pulse at the end of each frame's stop bit.
- txBusy  output  1  high while a frame is in progress (states START/DATA/STOP).
- fifoFull  output  1  registered count == DEPTH.
- fifoEmpty  output  1  registered count == 0.
- fifoCount  output  AW+1  number of bytes queued, not including the frame in flight.
- overflowFlag  output  1  sticky; set when sendStart=1 while fifoFull=1. Cleared only by reset.

Behaviour:
- Reset (rstnInput=0, applied asynchronously):
  - txOutput=1.
  - sendCompFlag=0, txBusy=0, overflowFlag=0.
  - fifoCount=0, fifoEmpty=1, fifoFull=0.
  - FSM=IDLE; read/write pointers, baud counter and bit counter all 0.
- Reset mid-frame: the line goes high immediately, and the in-flight byte and all queued bytes are discarded.
- FIFO:
  - Circular buffer with pointers wrapping modulo DEPTH.
  - Write occurs on an edge where sendStart=1 and fifoFull=0. A write attempted while full is dropped and sets overflowFlag; FIFO contents are unchanged.
  - Pop occurs only when the FSM loads a byte, and only if fifoEmpty=0.
  - Simultaneous write and pop: fifoCount is unchanged, and both the data and pointer updates take effect.
  - Full/empty decisions use the registered count. A write in the same cycle as a pop while full is still rejected.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txOutput=1. If fifoEmpty=0, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: txOutput=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: txOutput=shift[0] for BAUD_DIV cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: txOutput=1 for BAUD_DIV cycles. On the final cycle, pulse sendCompFlag for one cycle. Then:
    - if fifoEmpty=0, pop the next byte and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter runs 0..BAUD_DIV-1. A bit ends when the counter equals BAUD_DIV-1, and the counter then returns to 0.
- Latency: for a write at edge N into an empty FIFO with the FSM in IDLE:
  - fifoEmpty falls after edge N;
  - the pop and IDLE->START transition happen at edge N+1;
  - txOutput falls after edge N+1.
- Frame length is exactly 10*BAUD_DIV cycles. Back-to-back frames have their start bits exactly 10*BAUD_DIV cycles apart.
- txOutput is registered, so no combinational glitches appear on the line.
- sendStart held high for k cycles enqueues k bytes: the value of sendData on each cycle, up to capacity.

Test Plan:
- Reset, then a single write of 0xA5 with BAUD_DIV=4:
  - txOutput falls 2 edges after the write;
  - the line sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
  - sendCompFlag pulses once at cycle 40 after the start;
  - fifoEmpty=1 and txBusy=0 afterwards.
- Burst of writes 0x00,0xFF,0x55 on 3 consecutive cycles:
  - fifoCount peaks at 2 (the first byte is popped immediately);
  - three frames are sent with no idle gap, with start bits 40 cycles apart;
  - there are 3 sendCompFlag pulses.
- Fill with DEPTH+1 writes while the line is busy:
  - fifoFull=1 after DEPTH queued bytes;
  - the extra write is dropped and overflowFlag=1;
  - all DEPTH queued bytes are transmitted in order, with no corruption.
- Write on the same edge as a STOP->START pop while fifoCount=DEPTH: the write is rejected, overflowFlag=1, and fifoCount=DEPTH-1 afterwards.
- Assert rstnInput low mid-DATA:
  - txOutput=1 immediately, without waiting for a clock edge;
  - no sendCompFlag pulse;
  - after release, fifoEmpty=1 and the line stays idle.
- Pointer wrap: write and drain 3*DEPTH distinct bytes (values 0..47 for DEPTH=16) in mixed bursts; a serial monitor receives them all in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes are pushed with a one-cycle write
//   strobe into a circular FIFO. A four-state FSM drains the FIFO one frame
//   at a time: start bit, 8 data bits LSB first, stop bit. Each bit lasts
//   BAUD_DIV clocks. If a byte is already queued when a stop bit ends, the
//   next frame starts on the very next cycle, with no idle gap.
//
// Ports
//   clkInput      system clock, rising edge
//   rstnInput     asynchronous active-low reset
//   sendData      byte to enqueue, sampled while sendStart is high
//   sendStart     write strobe, one byte per high cycle when not full
//   txOutput      registered serial line, idle high
//   sendCompFlag  one-cycle pulse during the final cycle of each stop bit
//   txBusy        a frame is in progress (START/DATA/STOP)
//   fifoFull      queued count == DEPTH
//   fifoEmpty     queued count == 0
//   fifoCount     bytes queued, excluding the frame on the line
//   overflowFlag  sticky: a write was attempted while full
module uart_tx_fifo #(
    parameter int BAUD_DIV = 434,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic          clkInput,
    input  logic          rstnInput,
    input  logic [7:0]    sendData,
    input  logic          sendStart,
    output logic          txOutput,
    output logic          sendCompFlag,
    output logic          txBusy,
    output logic          fifoFull,
    output logic          fifoEmpty,
    output logic [AW:0]   fifoCount,
    output logic          overflowFlag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    fifoMem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          wrEn;
    logic          popEn;
    logic [7:0]    headByte;

    assign fifoFull  = (count == FULL_CNT);
    assign fifoEmpty = (count == '0);
    assign fifoCount = count;
    assign headByte  = fifoMem[rdPtr];

    // Full is judged on the registered count. A write that lands on the
    // same edge as a pop from a full FIFO is therefore still rejected.
    assign wrEn = sendStart && !fifoFull;

    always_ff @(posedge clkInput) begin
        if (wrEn) begin
            fifoMem[wrPtr] <= sendData;
        end
    end

    always_ff @(posedge clkInput or negedge rstnInput) begin
        if (!rstnInput) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            overflowFlag <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({wrEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sendStart && fifoFull) begin
                overflowFlag <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    txState_t    state;
    txState_t    stateNext;
    logic [15:0] baudCnt;
    logic [15:0] baudNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic        txReg;
    logic        txNext;
    logic        bitEnd;

    assign bitEnd       = (baudCnt == BIT_END);
    assign txOutput     = txReg;
    assign txBusy       = (state != IDLE);
    assign sendCompFlag = (state == STOP) && bitEnd;

    always_ff @(posedge clkInput or negedge rstnInput) begin
        if (!rstnInput) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

    // txNext is the level the line takes after this edge. That is why each
    // transition loads the first level of the state it enters.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = txReg;
        popEn     = 1'b0;

        unique case (state)
            IDLE: begin
                txNext = 1'b1;
                if (!fifoEmpty) begin
                    popEn     = 1'b1;
                    shiftNext = headByte;
                    baudNext  = '0;
                    bitNext   = '0;
                    txNext    = 1'b0;
                    stateNext = START;
                end
            end

            START: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    bitNext   = '0;
                    txNext    = shiftReg[0];
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    shiftNext = {1'b0, shiftReg[7:1]};
                    if (bitIdx == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        bitNext = bitIdx + 3'd1;
                        // The next bit is still at [1]. The shift only
                        // takes effect on this same edge.
                        txNext  = shiftReg[1];
                    end
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end

            STOP: begin
                txNext = 1'b1;
                if (bitEnd) begin
                    baudNext = '0;
                    if (!fifoEmpty) begin
                        // Chain straight into the next frame, with no idle cycle.
                        popEn     = 1'b1;
                        shiftNext = headByte;
                        bitNext   = '0;
                        txNext    = 1'b0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end

            default: begin
                txNext    = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int BAUD  = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 10 * BAUD;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    sendData = 8'h00;
    logic          sendStart = 1'b0;
    logic          txOutput;
    logic          sendCompFlag;
    logic          txBusy;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [AW:0]   fifoCount;
    logic          overflowFlag;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BAUD), .DEPTH(DEPTH), .AW(AW)) dut (
        .clkInput     (clk),
        .rstnInput    (rstn),
        .sendData     (sendData),
        .sendStart    (sendStart),
        .txOutput     (txOutput),
        .sendCompFlag (sendCompFlag),
        .txBusy       (txBusy),
        .fifoFull     (fifoFull),
        .fifoEmpty    (fifoEmpty),
        .fifoCount    (fifoCount),
        .overflowFlag (overflowFlag)
    );

    int          nCmp = 0;
    int          nBad = 0;
    int          cyc = 0;
    int          compCnt = 0;
    int          rxCnt = 0;
    bit          monEn = 1'b1;
    logic [7:0]  expQ[$];
    logic [9:0]  rxQ[$];     // {start-bit level, stop-bit level, byte}
    int          startQ[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sendCompFlag === 1'b1) compCnt <= compCnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Serial receiver: samples each bit at mid-cell on negedges.
    initial begin : monitor
        logic [7:0] rx;
        logic       stb;
        forever begin
            @(negedge clk);
            if (monEn && rstn && txOutput === 1'b0) begin
                startQ.push_back(cyc);
                repeat (BAUD / 2) @(negedge clk);
                stb = txOutput;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    rx[i] = txOutput;
                end
                repeat (BAUD) @(negedge clk);
                rxQ.push_back({stb, txOutput, rx});
            end
        end
    end

    // One clock step; any byte the receiver has finished is scored here.
    task automatic step();
        logic [9:0] rec;
        @(negedge clk);
        while (rxQ.size() != 0) begin
            rec = rxQ.pop_front();
            rxCnt++;
            chk("rx_framing", {30'd0, rec[9:8]}, 32'd1);
            if (expQ.size() == 0) begin
                nCmp++;
                nBad++;
                $display("FAIL rx_unexpected: got 0x%02h, expected no byte", rec[7:0]);
            end else begin
                chk("rx_byte", {24'd0, rec[7:0]}, {24'd0, expQ.pop_front()});
            end
        end
    endtask

    task automatic drain(input string name, input int maxCyc);
        int n;
        n = 0;
        while ((expQ.size() != 0 || rxQ.size() != 0 || txBusy || !fifoEmpty) && n < maxCyc) begin
            step();
            n++;
        end
        chk(name, (n < maxCyc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       accept;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       busy;
        logic       ovf;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[19];
        int   lineA[10];
        int   bs[6];
        int   n, bad, pulses, compAt, s0, c0, r0, peak, v;

        // Vector table for the fill / overflow sequence
        for (int k = 0; k < 19; k++) begin
            vt[k].start  = (k < 18);
            vt[k].data   = 8'(8'h10 + k);
            vt[k].accept = (k < 17);
            vt[k].cnt    = (k == 0) ? 5'd1 : ((k <= 16) ? 5'(k) : 5'd16);
            vt[k].full   = (vt[k].cnt == 5'd16);
            vt[k].empty  = 1'b0;
            vt[k].busy   = (k != 0);
            vt[k].ovf    = (k >= 17);
        end
        lineA = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        bs    = '{5, 12, 3, 16, 7, 5};

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_tx", txOutput, 1);
        chk("rst_comp", sendCompFlag, 0);
        chk("rst_busy", txBusy, 0);
        chk("rst_ovf", overflowFlag, 0);
        chk("rst_count", fifoCount, 0);
        chk("rst_empty", fifoEmpty, 1);
        chk("rst_full", fifoFull, 0);
        rstn = 1'b1;
        step();

        // ---------------- A: single 0xA5 ----------------
        expQ.push_back(8'hA5);
        sendStart = 1'b1; sendData = 8'hA5;
        step();
        sendStart = 1'b0;
        chk("a_empty_after_wr", fifoEmpty, 0);
        chk("a_tx_idle_after_wr", txOutput, 1);
        chk("a_busy_after_wr", txBusy, 0);
        step();
        chk("a_tx_fell", txOutput, 0);
        chk("a_busy", txBusy, 1);
        bad = 0; pulses = 0; compAt = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            if (txOutput !== lineA[i / BAUD][0]) bad++;
            if (sendCompFlag === 1'b1) begin pulses++; compAt = i; end
        end
        chk("a_line_bits", bad, 0);
        chk("a_comp_pulses", pulses, 1);
        chk("a_comp_cycle", compAt, FRAME - 1);
        step();
        chk("a_busy_after", txBusy, 0);
        chk("a_empty_after", fifoEmpty, 1);
        chk("a_tx_after", txOutput, 1);
        drain("a_drain", 100);

        // ---------------- B: burst 00,FF,55 ----------------
        s0 = startQ.size(); c0 = compCnt; peak = 0;
        for (int i = 0; i < 3; i++) begin
            sendStart = 1'b1;
            sendData = (i == 0) ? 8'h00 : ((i == 1) ? 8'hFF : 8'h55);
            expQ.push_back(sendData);
            step();
            if (int'(fifoCount) > peak) peak = int'(fifoCount);
        end
        sendStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int'(fifoCount) > peak) peak = int'(fifoCount);
        end
        chk("b_count_peak", peak, 2);
        drain("b_drain", 4 * FRAME);
        chk("b_frames", startQ.size() - s0, 3);
        if (startQ.size() - s0 == 3) begin
            chk("b_gap1", startQ[s0 + 1] - startQ[s0], FRAME);
            chk("b_gap2", startQ[s0 + 2] - startQ[s0 + 1], FRAME);
        end
        chk("b_comp_pulses", compCnt - c0, 3);

        // ---------------- C: write collides with pop while full ----------------
        for (int i = 0; i < DEPTH + 1; i++) begin
            sendStart = 1'b1; sendData = 8'(8'h80 + i);
            expQ.push_back(sendData);
            step();
        end
        sendStart = 1'b0;
        chk("c_count_full", fifoCount, DEPTH);
        chk("c_full", fifoFull, 1);
        n = 0;
        while (sendCompFlag !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
        chk("c_comp_seen", (n < 2 * FRAME) ? 32'd1 : 32'd0, 32'd1);
        chk("c_count_pre_pop", fifoCount, DEPTH);
        chk("c_ovf_pre", overflowFlag, 0);
        sendStart = 1'b1; sendData = 8'hEE;      // rejected: must not be queued
        step();
        sendStart = 1'b0;
        chk("c_count_post", fifoCount, DEPTH - 1);
        chk("c_ovf_post", overflowFlag, 1);
        chk("c_full_post", fifoFull, 0);
        chk("c_busy_post", txBusy, 1);
        drain("c_drain", (DEPTH + 3) * FRAME);

        // ---------------- D: table-driven fill + overflow ----------------
        rstn = 1'b0;
        step();
        chk("d_rst_ovf", overflowFlag, 0);
        rstn = 1'b1;
        step();
        for (int k = 0; k < 19; k++) begin
            sendStart = vt[k].start;
            sendData  = vt[k].data;
            if (vt[k].start && vt[k].accept) expQ.push_back(vt[k].data);
            step();
            chk($sformatf("d_cnt[%0d]", k), fifoCount, vt[k].cnt);
            chk($sformatf("d_full[%0d]", k), fifoFull, vt[k].full);
            chk($sformatf("d_empty[%0d]", k), fifoEmpty, vt[k].empty);
            chk($sformatf("d_busy[%0d]", k), txBusy, vt[k].busy);
            chk($sformatf("d_ovf[%0d]", k), overflowFlag, vt[k].ovf);
        end
        sendStart = 1'b0;
        drain("d_drain", (DEPTH + 3) * FRAME);

        // ---------------- E: reset mid-DATA ----------------
        monEn = 1'b0;
        step();
        sendStart = 1'b1; sendData = 8'h3C;
        step();
        sendData = 8'h00;
        step();
        sendStart = 1'b0;
        chk("e_tx_start", txOutput, 0);
        repeat (6) step();                      // mid data bit 0 (0x3C bit0 = 0)
        chk("e_tx_data0", txOutput, 0);
        chk("e_count_pre", fifoCount, 1);
        c0 = compCnt;
        #2 rstn = 1'b0;
        #1;
        chk("e_tx_async", txOutput, 1);
        chk("e_busy_async", txBusy, 0);
        chk("e_count_async", fifoCount, 0);
        repeat (2) step();
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (txOutput !== 1'b1 || sendCompFlag !== 1'b0 || txBusy !== 1'b0) bad++;
        end
        chk("e_line_idle", bad, 0);
        chk("e_no_comp", compCnt - c0, 0);
        chk("e_empty_after", fifoEmpty, 1);
        monEn = 1'b1;

        // ---------------- F: pointer wrap, 48 bytes in mixed bursts ----------------
        r0 = rxCnt; v = 0;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < bs[b]; j++) begin
                sendStart = 1'b1; sendData = 8'(v);
                expQ.push_back(sendData);
                v++;
                step();
            end
            sendStart = 1'b0;
            n = 0;
            while (!fifoEmpty && n < (DEPTH + 2) * FRAME) begin step(); n++; end
            repeat ($urandom_range(0, 60)) step();
        end
        drain("f_drain", (3 * DEPTH + 4) * FRAME);
        chk("f_rx_count", rxCnt - r0, 3 * DEPTH);
        chk("f_sent_count", v, 3 * DEPTH);
        chk("f_ovf", overflowFlag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
